riscv_aes_regbank: RTL and testbench
====================================

# riscv_aes_regbank

Parametrised AES operand register bank for the RISC-V AES extension: holds the cipher state words, multiple key slots and the write-back base address. It adds command handshaking, sequential (auto-increment) state loading, per-slot validity tracking and a streaming drain of the state to the write-back path. It sits between the decoder/ALU write port and the AES datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every word
- NUM_WORDS, 4, state words (power of two, ≥2); AW = $clog2(NUM_WORDS)
- NUM_KEYS, 2, key slots (power of two, ≥2); KW = $clog2(NUM_KEYS)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- test_en_i  in  1  test mode; forces all state words to all-ones
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  3  opcode (see Operation)
- cmd_addr_i  in  AW  word index
- cmd_slot_i  in  KW  key slot
- cmd_wdata_i  in  DATA_WIDTH  write data
- key_sel_i  in  KW  slot shown on key_o
- state_o  out  NUM_WORDS*DATA_WIDTH  state words; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- key_o  out  NUM_WORDS*DATA_WIDTH  key words of slot key_sel_i, same packing (combinational mux)
- state_valid_o  out  1  every state word written since the last clear
- key_valid_o  out  NUM_KEYS  per-slot: every word of that slot written
- wb_addr_o  out  DATA_WIDTH  write-back base address
- out_valid_o / out_ready_i  out / in  1 / 1  drain stream handshake
- out_data_o  out  DATA_WIDTH  drained word
- out_addr_o  out  DATA_WIDTH  wb_addr + 4*index, modulo 2^DATA_WIDTH
- err_o  out  1  write-to-locked-slot pulse

## Operation
- A command is accepted when cmd_valid_i && cmd_ready_o; its effect is visible on the next clk edge.
- Opcodes:
  - 0 WR_STATE: state[addr] ← wdata.
  - 1 WR_KEY: key[slot][addr] ← wdata.
  - 2 WR_WBADDR: wb_addr ← wdata.
  - 3 WR_SEQ: state[ptr] ← wdata, then ptr ← ptr+1, wrapping NUM_WORDS-1→0. addr is ignored.
  - 4 CLR: zero all state and key words, written masks, ptr and locks; wb_addr is kept.
  - 5 DRAIN: enter DRAIN.
  - 6 LOCK: see Configuration.
  - 7: accepted, no effect.
- Written tracking: one per-word mask for the state and one per key slot. state_valid_o = &state mask. key_valid_o[s] = &key mask[s]. WR_STATE does not move ptr.
- FSM IDLE/DRAIN:
  - IDLE: cmd_ready_o=1, out_valid_o=0. An accepted DRAIN sets idx←0 and moves to DRAIN.
  - DRAIN: cmd_ready_o=0, out_valid_o=1, out_data_o=state[idx]. On out_ready_i, idx increments. The beat with idx=NUM_WORDS-1 accepted returns the FSM to IDLE.
  - out_data_o and out_addr_o are held stable while out_valid_o && !out_ready_i.
- test_en_i=1 has priority over any command: all state words become all-ones and all state-mask bits are set. Keys, wb_addr and the FSM are unaffected, and the command is still accepted.

## Timing
- Reset (rst_n=0 at an edge) sets: all state/key/wb_addr = 0, masks/ptr/idx/locks = 0, FSM = IDLE.
- Output values after reset: cmd_ready_o=1, out_valid_o=0, state_valid_o=0, key_valid_o=0, err_o=0, out_data_o=0, out_addr_o=0.
- Write latency: 1 cycle. state_valid_o rises the cycle after the last missing word is written.
- Drain: first beat appears 1 cycle after DRAIN is accepted. With out_ready_i held high, NUM_WORDS beats take NUM_WORDS cycles, and cmd_ready_o returns on the cycle after the last beat.
- Reset during DRAIN: out_valid_o=0 and FSM=IDLE on the next edge; no further beats.
- A WR_SEQ accepted with ptr=NUM_WORDS-1 writes the last word and wraps ptr to 0 in the same edge.

## Configuration
- AES_REGBANK_KEY_LOCK_EN defined:
  - LOCK sets lock[slot].
  - WR_KEY to a locked slot is accepted but writes nothing, and err_o is high for exactly 1 cycle (the cycle after acceptance).
  - Locks are cleared only by reset or CLR.
- Not defined: LOCK is a no-op, no lock storage exists, and err_o is tied 0.

## Test plan
- Reset, then WR_SEQ 0xA0,0xA1,0xA2,0xA3 → state_o words 0..3 = 0xA0..0xA3, ptr=0, state_valid_o rises after the 4th write.
- WR_KEY slot1 addr0..3 = 0x11..0x14 with key_sel_i=1 → key_o = those words, key_valid_o=2'b10; key_sel_i=0 → key_o=0.
- WR_WBADDR 0x1000, then DRAIN with out_ready_i toggling 1,0,1,1,1 → beats (0xA0,0x1000), (0xA1,0x1004), (0xA2,0x1008), (0xA3,0x100C); data held stable while ready=0; cmd_ready_o=0 throughout the drain.
- WR_WBADDR 0xFFFFFFFC, then DRAIN → out_addr_o sequence 0xFFFFFFFC, 0x0, 0x4, 0x8 (wrap-around).
- test_en_i=1 together with WR_STATE addr2=0x5 → all state words = 0xFFFFFFFF, state_valid_o=1, keys unchanged. Separately, rst_n=0 at mid-drain beat 2 → out_valid_o=0 and all outputs at reset values next cycle.
- With AES_REGBANK_KEY_LOCK_EN: LOCK slot0, then WR_KEY slot0 addr0=0xDEAD → key unchanged, err_o single-cycle pulse; CLR then retry → write succeeds, err_o=0.

Source files
------------

// File: rtl/riscv_aes_regbank_if.sv
// Command and drain-stream bundle for riscv_aes_regbank.
// master: decoder/ALU + write-back consumer side; slave: the register bank.
interface riscv_aes_regbank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned NUM_KEYS   = 2
);
  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned KW = $clog2(NUM_KEYS);

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [2:0]            cmd_op_i;
  logic [AW-1:0]         cmd_addr_i;
  logic [KW-1:0]         cmd_slot_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [DATA_WIDTH-1:0] out_addr_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_slot_i, cmd_wdata_i, out_ready_i,
    input  cmd_ready_o, out_valid_o, out_data_o, out_addr_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_slot_i, cmd_wdata_i, out_ready_i,
    output cmd_ready_o, out_valid_o, out_data_o, out_addr_o
  );
endinterface

// File: rtl/riscv_aes_regbank.sv
// AES operand register bank: state words, key slots, write-back base address,
// sequential state loading, validity tracking and a streaming state drain.
// Optional feature macro: AES_REGBANK_KEY_LOCK_EN (per-slot key write locks, err_o pulse).
module riscv_aes_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned NUM_KEYS   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            test_en_i,
  riscv_aes_regbank_if.slave              bus,
  input  logic [$clog2(NUM_KEYS)-1:0]     key_sel_i,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] state_o,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] key_o,
  output logic                            state_valid_o,
  output logic [NUM_KEYS-1:0]             key_valid_o,
  output logic [DATA_WIDTH-1:0]           wb_addr_o,
  output logic                            err_o
);
  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [AW-1:0] LastIdx = AW'(NUM_WORDS - 1);

  localparam logic [2:0] OpWrState  = 3'd0;
  localparam logic [2:0] OpWrKey    = 3'd1;
  localparam logic [2:0] OpWrWbAddr = 3'd2;
  localparam logic [2:0] OpWrSeq    = 3'd3;
  localparam logic [2:0] OpClr      = 3'd4;
  localparam logic [2:0] OpDrain    = 3'd5;
  localparam logic [2:0] OpLock     = 3'd6;
  localparam logic [2:0] OpNop      = 3'd7;

  typedef enum logic [0:0] {StIdle, StDrain} fsm_e;

  fsm_e                              fsm_q, fsm_d;
  logic [DATA_WIDTH-1:0]             state_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0]             key_q   [NUM_KEYS][NUM_WORDS];
  logic [NUM_WORDS-1:0]              state_mask_q;
  logic [NUM_KEYS-1:0][NUM_WORDS-1:0] key_mask_q;
  logic [DATA_WIDTH-1:0]             wb_addr_q;
  logic [AW-1:0]                     ptr_q;
  logic [AW-1:0]                     idx_q;
  logic                              cmd_ready;
  logic                              out_valid;
  logic                              cmd_fire;
  logic                              key_locked;

  assign cmd_fire = bus.cmd_valid_i && cmd_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= StIdle;
    else        fsm_q <= fsm_d;
  end

  // FSM next state: leave IDLE on an accepted DRAIN, return after the last beat.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (cmd_fire && bus.cmd_op_i == OpDrain) fsm_d = StDrain;
      StDrain: if (bus.out_ready_i && idx_q == LastIdx) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // FSM outputs: commands only in IDLE, stream valid only in DRAIN.
  always_comb begin
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      StIdle:  cmd_ready = 1'b1;
      StDrain: out_valid = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Drain index: restarts on DRAIN acceptance, advances per accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (cmd_fire && bus.cmd_op_i == OpDrain) begin
      idx_q <= '0;
    end else if (out_valid && bus.out_ready_i) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Register file writes; test mode overrides the state words last so it wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        state_q[w] <= '0;
        for (int s = 0; s < NUM_KEYS; s++) key_q[s][w] <= '0;
      end
      state_mask_q <= '0;
      key_mask_q   <= '0;
      wb_addr_q    <= '0;
      ptr_q        <= '0;
    end else begin
      if (cmd_fire) begin
        unique case (bus.cmd_op_i)
          OpWrState: begin
            state_q[bus.cmd_addr_i]      <= bus.cmd_wdata_i;
            state_mask_q[bus.cmd_addr_i] <= 1'b1;
          end
          OpWrKey: begin
            if (!key_locked) begin
              key_q[bus.cmd_slot_i][bus.cmd_addr_i]      <= bus.cmd_wdata_i;
              key_mask_q[bus.cmd_slot_i][bus.cmd_addr_i] <= 1'b1;
            end
          end
          OpWrWbAddr: wb_addr_q <= bus.cmd_wdata_i;
          OpWrSeq: begin
            state_q[ptr_q]      <= bus.cmd_wdata_i;
            state_mask_q[ptr_q] <= 1'b1;
            ptr_q               <= ptr_q + 1'b1;  // power-of-two depth wraps naturally
          end
          OpClr: begin
            for (int w = 0; w < NUM_WORDS; w++) begin
              state_q[w] <= '0;
              for (int s = 0; s < NUM_KEYS; s++) key_q[s][w] <= '0;
            end
            state_mask_q <= '0;
            key_mask_q   <= '0;
            ptr_q        <= '0;
          end
          OpDrain, OpLock, OpNop: ;
        endcase
      end
      if (test_en_i) begin
        for (int w = 0; w < NUM_WORDS; w++) state_q[w] <= '1;
        state_mask_q <= '1;
      end
    end
  end

`ifdef AES_REGBANK_KEY_LOCK_EN
  logic [NUM_KEYS-1:0] lock_q;
  logic                err_q;

  // Locks persist until reset or CLR; a write to a locked slot pulses err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= cmd_fire && bus.cmd_op_i == OpWrKey && lock_q[bus.cmd_slot_i];
      if (cmd_fire && bus.cmd_op_i == OpClr) lock_q <= '0;
      else if (cmd_fire && bus.cmd_op_i == OpLock) lock_q[bus.cmd_slot_i] <= 1'b1;
    end
  end

  assign key_locked = lock_q[bus.cmd_slot_i];
  assign err_o      = err_q;
`else
  assign key_locked = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Packed views of state and the selected key slot, plus validity summaries.
  always_comb begin
    state_o     = '0;
    key_o       = '0;
    key_valid_o = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      state_o[w*DATA_WIDTH +: DATA_WIDTH] = state_q[w];
      key_o[w*DATA_WIDTH +: DATA_WIDTH]   = key_q[key_sel_i][w];
    end
    for (int s = 0; s < NUM_KEYS; s++) key_valid_o[s] = &key_mask_q[s];
  end

  assign state_valid_o   = &state_mask_q;
  assign wb_addr_o       = wb_addr_q;
  assign bus.cmd_ready_o = cmd_ready;
  assign bus.out_valid_o = out_valid;
  // Stream fields are zero outside DRAIN; inside they only depend on idx, so they hold.
  assign bus.out_data_o  = out_valid ? state_q[idx_q] : '0;
  assign bus.out_addr_o  = out_valid ? wb_addr_q + (DATA_WIDTH'(idx_q) << 2) : '0;
endmodule

// File: tb/tb_riscv_aes_regbank.sv
// Self-checking bench for riscv_aes_regbank (DATA_WIDTH=32, NUM_WORDS=4, NUM_KEYS=2).
module tb_riscv_aes_regbank;
  logic         clk;
  logic         rst_n;
  logic         test_en;
  logic         key_sel;
  logic [127:0] state_o;
  logic [127:0] key_o;
  logic         state_valid;
  logic [1:0]   key_valid;
  logic [31:0]  wb_addr;
  logic         err;

  int compared = 0;
  int mismatched = 0;

`ifdef AES_REGBANK_KEY_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  riscv_aes_regbank_if #(.DATA_WIDTH(32), .NUM_WORDS(4), .NUM_KEYS(2)) bus ();

  riscv_aes_regbank #(.DATA_WIDTH(32), .NUM_WORDS(4), .NUM_KEYS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .test_en_i     (test_en),
    .bus           (bus),
    .key_sel_i     (key_sel),
    .state_o       (state_o),
    .key_o         (key_o),
    .state_valid_o (state_valid),
    .key_valid_o   (key_valid),
    .wb_addr_o     (wb_addr),
    .err_o         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the bank contents.
  logic [31:0] m_state [4];
  logic [31:0] m_key   [2][4];
  logic [3:0]  m_smask;
  logic [3:0]  m_kmask [2];
  logic [31:0] m_wb;
  int          m_ptr;
  logic [1:0]  m_lock;
  logic        m_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = 0; m_key[0][i] = 0; m_key[1][i] = 0;
    end
    m_smask = 0; m_kmask[0] = 0; m_kmask[1] = 0;
    m_wb = 0; m_ptr = 0; m_lock = 0; m_err = 0;
  endtask

  task automatic model_apply(input int op, input int addr, input int slot, input logic [31:0] d);
    m_err = 0;
    case (op)
      0: begin m_state[addr] = d; m_smask[addr] = 1'b1; end
      1: begin
        if (LockEn && m_lock[slot]) m_err = 1;
        else begin m_key[slot][addr] = d; m_kmask[slot][addr] = 1'b1; end
      end
      2: m_wb = d;
      3: begin m_state[m_ptr] = d; m_smask[m_ptr] = 1'b1; m_ptr = (m_ptr + 1) % 4; end
      4: begin
        for (int i = 0; i < 4; i++) begin
          m_state[i] = 0; m_key[0][i] = 0; m_key[1][i] = 0;
        end
        m_smask = 0; m_kmask[0] = 0; m_kmask[1] = 0; m_ptr = 0; m_lock = 0;
      end
      6: if (LockEn) m_lock[slot] = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic [127:0] exp_state();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = m_state[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_key(input int s);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = m_key[s][i];
    return v;
  endfunction

  function automatic logic [1:0] exp_kvalid();
    return {&m_kmask[1], &m_kmask[0]};
  endfunction

  // Presents one command for a single edge and mirrors it into the model.
  task automatic do_cmd(input int op, input int addr, input int slot, input logic [31:0] d);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = 3'(op);
    bus.cmd_addr_i  = 2'(addr);
    bus.cmd_slot_i  = 1'(slot);
    bus.cmd_wdata_i = d;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    model_apply(op, addr, slot, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compared++;
    if (bus.cmd_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hs: ready=%b valid=%b, required 1 0", bus.cmd_ready_o, bus.out_valid_o);
    end
    compared++;
    if (state_valid !== 1'b0 || key_valid !== 2'b00 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: sv=%b kv=%b err=%b, required 0 00 0", state_valid, key_valid, err);
    end
    compared++;
    if (bus.out_data_o !== 32'h0 || bus.out_addr_o !== 32'h0 || wb_addr !== 32'h0 ||
        state_o !== 128'h0) begin
      mismatched++;
      $display("FAIL reset_data: data=%h addr=%h wb=%h state=%h, required all 0",
               bus.out_data_o, bus.out_addr_o, wb_addr, state_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_seq_load();
    for (int i = 0; i < 4; i++) begin
      do_cmd(3, 3 - i, 0, 32'hA0 + 32'(i));
      compared++;
      if (state_o !== exp_state() || state_valid !== &m_smask) begin
        mismatched++;
        $display("FAIL seq_load[%0d]: state=%h sv=%b, required %h %b",
                 i, state_o, state_valid, exp_state(), &m_smask);
      end
    end
    // Pointer must have wrapped: next sequential write lands in word 0.
    do_cmd(3, 2, 0, 32'hB0);
    compared++;
    if (state_o !== exp_state()) begin
      mismatched++;
      $display("FAIL seq_wrap: state=%h, required %h", state_o, exp_state());
    end
    do_cmd(0, 0, 0, 32'hA0);
    compared++;
    if (state_o !== exp_state()) begin
      mismatched++;
      $display("FAIL wr_state: state=%h, required %h", state_o, exp_state());
    end
  endtask

  task automatic test_key();
    key_sel = 1'b1;
    for (int i = 0; i < 4; i++) do_cmd(1, i, 1, 32'h11 + 32'(i));
    compared++;
    if (key_o !== exp_key(1) || key_valid !== exp_kvalid()) begin
      mismatched++;
      $display("FAIL key_slot1: key=%h kv=%b, required %h %b", key_o, key_valid, exp_key(1),
               exp_kvalid());
    end
    key_sel = 1'b0;
    #1;
    compared++;
    if (key_o !== exp_key(0)) begin
      mismatched++;
      $display("FAIL key_slot0: key=%h, required %h", key_o, exp_key(0));
    end
  endtask

  // Drains the state; pat gives out_ready per cycle (bit 0 first), rnd picks random ready.
  task automatic run_drain(input string name, input logic [7:0] pat, input bit rnd);
    int   beat = 0;
    int   cyc = 0;
    logic rdy;
    do_cmd(5, 0, 0, 32'h0);
    while (beat < 4 && cyc < 40) begin
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else     rdy = (cyc < 8) ? pat[cyc] : 1'b1;
      bus.out_ready_i = rdy;
      compared++;
      if (bus.out_valid_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_hs[%0d]: valid=%b ready=%b, required 1 0", name, beat,
                 bus.out_valid_o, bus.cmd_ready_o);
      end
      compared++;
      if (bus.out_data_o !== m_state[beat] || bus.out_addr_o !== m_wb + 32'(4 * beat)) begin
        mismatched++;
        $display("FAIL %s_beat[%0d]: data=%h addr=%h, required %h %h", name, beat,
                 bus.out_data_o, bus.out_addr_o, m_state[beat], m_wb + 32'(4 * beat));
      end
      @(posedge clk); #1;
      if (rdy) beat++;
      cyc++;
    end
    bus.out_ready_i = 1'b0;
    compared++;
    if (beat != 4 || bus.out_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_end: beats=%0d valid=%b ready=%b, required 4 0 1", name, beat,
               bus.out_valid_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_drain();
    do_cmd(2, 0, 0, 32'h1000);
    compared++;
    if (wb_addr !== 32'h1000) begin
      mismatched++;
      $display("FAIL wbaddr: got %h, required 00001000", wb_addr);
    end
    run_drain("drain", 8'b1111_1101, 1'b0);
    do_cmd(2, 0, 0, 32'hFFFF_FFFC);
    run_drain("drain_wrap", 8'hFF, 1'b0);
    run_drain("drain_rnd", 8'h00, 1'b1);
  endtask

  task automatic test_random();
    int ops [7] = '{0, 1, 2, 3, 4, 6, 7};
    for (int n = 0; n < 60; n++) begin
      key_sel = 1'($urandom_range(0, 1));
      do_cmd(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 1), $urandom);
      compared++;
      if (state_o !== exp_state() || key_o !== exp_key(key_sel) || wb_addr !== m_wb) begin
        mismatched++;
        $display("FAIL rand_data[%0d]: state=%h key=%h wb=%h, required %h %h %h", n, state_o,
                 key_o, wb_addr, exp_state(), exp_key(key_sel), m_wb);
      end
      compared++;
      if (state_valid !== &m_smask || key_valid !== exp_kvalid() || err !== m_err) begin
        mismatched++;
        $display("FAIL rand_flags[%0d]: sv=%b kv=%b err=%b, required %b %b %b", n, state_valid,
                 key_valid, err, &m_smask, exp_kvalid(), m_err);
      end
    end
  endtask

  task automatic test_test_en();
    test_en = 1'b1;
    do_cmd(0, 2, 0, 32'h5);
    test_en = 1'b0;
    for (int i = 0; i < 4; i++) m_state[i] = 32'hFFFF_FFFF;
    m_smask = 4'hF;
    compared++;
    if (state_o !== exp_state() || state_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL test_en_state: state=%h sv=%b, required %h 1", state_o, state_valid,
               exp_state());
    end
    for (int s = 0; s < 2; s++) begin
      key_sel = 1'(s);
      #1;
      compared++;
      if (key_o !== exp_key(s)) begin
        mismatched++;
        $display("FAIL test_en_key%0d: key=%h, required %h", s, key_o, exp_key(s));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    do_cmd(2, 0, 0, 32'h2000);
    do_cmd(5, 0, 0, 32'h0);
    bus.out_ready_i = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    compared++;
    if (bus.out_valid_o !== 1'b1 || bus.out_addr_o !== 32'h2008) begin
      mismatched++;
      $display("FAIL mid_drain: valid=%b addr=%h, required 1 00002008", bus.out_valid_o,
               bus.out_addr_o);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    compared++;
    if (bus.out_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.out_data_o !== 32'h0 ||
        bus.out_addr_o !== 32'h0 || state_o !== 128'h0 || wb_addr !== 32'h0 ||
        state_valid !== 1'b0 || key_valid !== 2'b00 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_reset: valid=%b ready=%b data=%h addr=%h wb=%h sv=%b kv=%b",
               bus.out_valid_o, bus.cmd_ready_o, bus.out_data_o, bus.out_addr_o, wb_addr,
               state_valid, key_valid);
    end
    rst_n = 1'b1;
    bus.out_ready_i = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (bus.out_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL drain_after_reset: valid=%b, required 0", bus.out_valid_o);
    end
  endtask

  task automatic test_lock();
    key_sel = 1'b0;
    do_cmd(6, 0, 0, 32'h0);
    do_cmd(1, 0, 0, 32'hDEAD);
`ifdef AES_REGBANK_KEY_LOCK_EN
    compared++;
    if (err !== 1'b1 || key_o !== 128'h0) begin
      mismatched++;
      $display("FAIL lock_block: err=%b key=%h, required 1 0", err, key_o);
    end
    @(posedge clk); #1;
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL lock_pulse: err=%b, required 0", err);
    end
    do_cmd(4, 0, 0, 32'h0);
    do_cmd(1, 0, 0, 32'hDEAD);
`endif
    compared++;
    if (err !== 1'b0 || key_o !== exp_key(0) || key_o[31:0] !== 32'hDEAD) begin
      mismatched++;
      $display("FAIL lock_write: err=%b key=%h, required 0 %h", err, key_o, exp_key(0));
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    test_en         = 1'b0;
    key_sel         = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 3'd0;
    bus.cmd_addr_i  = 2'd0;
    bus.cmd_slot_i  = 1'b0;
    bus.cmd_wdata_i = 32'h0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_seq_load();
    test_key();
    test_drain();
    test_random();
    test_test_en();
    test_reset_mid_drain();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
